// File: rtl/nfc_op_sequencer_pkg.sv
// nfc_op_sequencer_pkg: NFC opcodes, targets, command record and sequencer state encoding
package nfc_op_sequencer_pkg;
  typedef enum logic [3:0] {
    IDLE, SEL_WAY, SET_COL, SET_ROW, ISSUE_OP, WAIT_OP, ISSUE_STAT, WAIT_STAT, CHECK, RESP
  } state_e;
  typedef enum logic [1:0] {OP_PROG, OP_READ, OP_ERASE, OP_RSVD} op_e;
  localparam logic [5:0] OPC_SEL_WAY = 6'b100000;
  localparam logic [5:0] OPC_SET_COL = 6'b100010;
  localparam logic [5:0] OPC_SET_ROW = 6'b100100;
  localparam logic [5:0] OPC_PROG    = 6'b000011;
  localparam logic [5:0] OPC_READ    = 6'b000100;
  localparam logic [5:0] OPC_ERASE   = 6'b000110;
  localparam logic [5:0] OPC_STATUS  = 6'b000111;
  localparam logic [4:0] TGT_NONE    = 5'b00000;
  localparam logic [4:0] TGT_CMD     = 5'b00101;
  localparam logic [4:0] TGT_STATUS  = 5'b00100;
  localparam logic [15:0] REG_LEN    = 16'h0008;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  target;
    logic [31:0] address;
    logic [15:0] length;
  } cmd_t;
  function automatic cmd_t cmd_for(state_e s, op_e op, logic [7:0] way, logic [23:0] row,
                                   logic [15:0] col, logic [15:0] len);
    cmd_t c;
    case (s)
      SEL_WAY:  c = '{OPC_SEL_WAY, TGT_NONE, {24'd0, way}, REG_LEN};
      SET_COL:  c = '{OPC_SET_COL, TGT_NONE, {16'd0, col}, REG_LEN};
      SET_ROW:  c = '{OPC_SET_ROW, TGT_NONE, {8'd0, row}, REG_LEN};
      ISSUE_OP: c = '{op == OP_PROG ? OPC_PROG : op == OP_READ ? OPC_READ : OPC_ERASE,
                      op == OP_PROG ? TGT_NONE : TGT_CMD, {8'd0, row}, len};
      default:  c = '{OPC_STATUS, TGT_STATUS, 32'd0, REG_LEN};
    endcase
    return c;
  endfunction
endpackage

// File: rtl/nfc_op_sequencer.sv
// nfc_op_sequencer: turns program/read/erase requests into NFC command sequences with status polling
module nfc_op_sequencer
  import nfc_op_sequencer_pkg::*;
#(
  parameter int NumberOfWays = 2,
  parameter int PollLimit    = 1024,
  localparam int WayW        = NumberOfWays > 1 ? $clog2(NumberOfWays) : 1
) (
  input  logic            iSystemClock,
  input  logic            iReset,
  input  logic            iReqValid,
  output logic            oReqReady,
  input  logic [1:0]      iReqOp,
  input  logic [WayW-1:0] iReqWay,
  input  logic [23:0]     iReqRow,
  input  logic [15:0]     iReqCol,
  input  logic [15:0]     iReqLength,
  output logic            oRspValid,
  input  logic            iRspReady,
  output logic [7:0]      oRspStatus,
  output logic            oRspTimeout,
  output logic            oRspFail,
  output logic [5:0]      oOpcode,
  output logic [4:0]      oTargetID,
  output logic [4:0]      oSourceID,
  output logic [31:0]     oAddress,
  output logic [15:0]     oLength,
  output logic            oCMDValid,
  input  logic            iCMDReady,
  input  logic [15:0]     iReadData,
  input  logic            iReadValid,
  input  logic            iReadLast,
  output logic            oReadReady
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [WayW-1:0] way_q, way_d;
  logic [23:0] row_q, row_d;
  logic [15:0] col_q, col_d, len_q, len_d, poll_q, poll_d;
  cmd_t cmd_q, cmd_d;
  logic cmd_valid_q, cmd_valid_d, rsp_valid_q, rsp_valid_d, read_ready_q, read_ready_d;
  logic first_q, first_d, timeout_q, timeout_d;
  logic [7:0] status_q, status_d;
  logic unused_read_hi;
  assign unused_read_hi = ^iReadData[15:8];
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    way_d = way_q;
    row_d = row_q;
    col_d = col_q;
    len_d = len_q;
    poll_d = poll_q;
    cmd_d = cmd_q;
    cmd_valid_d = cmd_valid_q;
    rsp_valid_d = rsp_valid_q;
    read_ready_d = read_ready_q;
    first_d = first_q;
    timeout_d = timeout_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (iReqValid) begin
        op_d = op_e'(iReqOp);
        way_d = iReqWay;
        row_d = iReqRow;
        col_d = iReqCol;
        len_d = iReqLength;
        timeout_d = 1'b0;
        status_d = iReqOp == OP_RSVD ? 8'hFF : 8'h00;
        rsp_valid_d = iReqOp == OP_RSVD;
        state_d = iReqOp == OP_RSVD ? RESP : SEL_WAY;
      end
      // A command is raised only after iCMDReady is seen high in the issuing state itself
      SEL_WAY, SET_COL, SET_ROW, ISSUE_OP, ISSUE_STAT: if (iCMDReady) begin
        cmd_valid_d = !cmd_valid_q;
        cmd_d = cmd_valid_q ? cmd_q : cmd_for(state_q, op_q, 8'(way_q), row_q, col_q, len_q);
        if (cmd_valid_q) begin
          state_d = state_q == SEL_WAY ? SET_COL : state_q == SET_COL ? SET_ROW :
                    state_q == SET_ROW ? ISSUE_OP : state_q == ISSUE_OP ? WAIT_OP : WAIT_STAT;
          poll_d = state_q == ISSUE_STAT && poll_q != 16'hFFFF ? poll_q + 16'd1 : poll_q;
          read_ready_d = state_q == ISSUE_STAT;
          first_d = 1'b1;
        end
      end
      WAIT_OP: if (iCMDReady) begin
        state_d = op_q == OP_READ ? RESP : ISSUE_STAT;
        rsp_valid_d = op_q == OP_READ;
      end
      WAIT_STAT: if (iReadValid) begin
        first_d = 1'b0;
        status_d = first_q ? iReadData[7:0] : status_q;
        read_ready_d = !iReadLast;
        state_d = iReadLast ? CHECK : WAIT_STAT;
      end
      CHECK: if (status_q[6] || poll_q == 16'(PollLimit)) begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        timeout_d = !status_q[6];
      end else if (iCMDReady) state_d = ISSUE_STAT;
      RESP: if (iRspReady) begin
        rsp_valid_d = 1'b0;
        poll_d = 16'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iSystemClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
      op_q <= OP_PROG;
      way_q <= '0;
      row_q <= '0;
      col_q <= '0;
      len_q <= '0;
      poll_q <= '0;
      cmd_q <= '0;
      cmd_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      read_ready_q <= 1'b0;
      first_q <= 1'b0;
      timeout_q <= 1'b0;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      way_q <= way_d;
      row_q <= row_d;
      col_q <= col_d;
      len_q <= len_d;
      poll_q <= poll_d;
      cmd_q <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rsp_valid_q <= rsp_valid_d;
      read_ready_q <= read_ready_d;
      first_q <= first_d;
      timeout_q <= timeout_d;
      status_q <= status_d;
    end
  end
  assign oReqReady = state_q == IDLE;
  assign oRspValid = rsp_valid_q;
  assign oRspStatus = status_q;
  assign oRspTimeout = timeout_q;
  assign oRspFail = status_q[0];
  assign oOpcode = cmd_q.opcode;
  assign oTargetID = cmd_q.target;
  assign oSourceID = 5'd0;
  assign oAddress = cmd_q.address;
  assign oLength = cmd_q.length;
  assign oCMDValid = cmd_valid_q;
  assign oReadReady = read_ready_q;
endmodule

// File: tb/tb_nfc_op_sequencer.sv
// tb_nfc_op_sequencer: directed and randomized checks of the NFC op sequencer against a spec-level model
module tb_nfc_op_sequencer;
  localparam int Ways = 4;
  localparam int Limit = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = 2'd0, req_way = 2'd0;
  logic [23:0] req_row = 24'd0;
  logic [15:0] req_col = 16'd0, req_len = 16'd0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, rsp_fail;
  logic [7:0] rsp_status;
  logic [5:0] opcode;
  logic [4:0] target, source;
  logic [31:0] address;
  logic [15:0] length;
  logic cmd_valid, cmd_ready = 1'b0;
  logic [15:0] rd_data = 16'd0;
  logic rd_valid = 1'b0, rd_last = 1'b0, rd_ready;
  int checks = 0, errors = 0;
  logic [7:0] stat_seq [8];
  int stat_n = 1;

  always #5 clk = ~clk;

  nfc_op_sequencer #(.NumberOfWays(Ways), .PollLimit(Limit)) dut (
    .iSystemClock(clk), .iReset(rst),
    .iReqValid(req_valid), .oReqReady(req_ready), .iReqOp(req_op), .iReqWay(req_way),
    .iReqRow(req_row), .iReqCol(req_col), .iReqLength(req_len),
    .oRspValid(rsp_valid), .iRspReady(rsp_ready), .oRspStatus(rsp_status),
    .oRspTimeout(rsp_timeout), .oRspFail(rsp_fail),
    .oOpcode(opcode), .oTargetID(target), .oSourceID(source), .oAddress(address), .oLength(length),
    .oCMDValid(cmd_valid), .iCMDReady(cmd_ready),
    .iReadData(rd_data), .iReadValid(rd_valid), .iReadLast(rd_last), .oReadReady(rd_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cmdw(logic [5:0] o, logic [4:0] t, logic [31:0] a, logic [15:0] l);
    return {o, t, 5'd0, a, l};
  endfunction

  function automatic logic [7:0] stat_of(int p);
    return stat_seq[(p - 1) < stat_n ? p - 1 : stat_n - 1];
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [1:0] way, input logic [23:0] row,
                        input logic [15:0] col, input logic [15:0] len, input bit stall_row,
                        input int rsp_hold, input bit abort);
    logic [63:0] got[$];
    logic [63:0] exp[$];
    logic [63:0] cur = 64'd0, held = 64'd0, m;
    logic [9:0] rsp_cap = 10'd0;
    logic [7:0] st;
    logic exp_to = 1'b0;
    int busy = 0, stall = 0, poll = 0, beat = 0, nb = 1, hold_left = 0, viol = 0, cyc = 0, np;
    bit pv = 0, pr = 0, prr = 0, seen = 0, done = 0;
    if (op != 2'd3) begin
      exp.push_back(cmdw(6'b100000, 5'd0, {24'd0, 6'd0, way}, 16'h0008));
      exp.push_back(cmdw(6'b100010, 5'd0, {16'd0, col}, 16'h0008));
      exp.push_back(cmdw(6'b100100, 5'd0, {8'd0, row}, 16'h0008));
      exp.push_back(cmdw(op == 2'd0 ? 6'b000011 : op == 2'd1 ? 6'b000100 : 6'b000110,
                         op == 2'd0 ? 5'b00000 : 5'b00101, 32'd0, len));
    end
    if (op == 2'd0 || op == 2'd2) begin
      np = Limit;
      for (int i = 1; i <= Limit; i++) if (stat_of(i)[6]) begin np = i; break; end
      for (int i = 0; i < np; i++) exp.push_back(cmdw(6'b000111, 5'b00100, 32'd0, 16'h0008));
      st = stat_of(np);
      exp_to = !st[6];
    end else st = op == 2'd3 ? 8'hFF : 8'h00;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("req_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_way = way; req_row = row; req_col = col; req_len = len;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (cmd_valid) begin
        cur = {opcode, target, source, address, length};
        if (!pv && !pr) viol++;
        if (pv && !pr && cur !== held) viol++;
      end else if (pv && !pr) viol++;
      if (cmd_valid && !pv)
        stall = (stall_row && opcode == 6'b100100) ? 5 :
                ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0);
      cmd_ready = (busy == 0 && stall == 0);
      if (busy > 0) busy--; else if (stall > 0) stall--;
      if (cmd_valid && cmd_ready) begin got.push_back(cur); busy = int'($urandom_range(0, 3)); end
      held = cur; pv = cmd_valid; pr = cmd_ready;
      if (rd_ready) begin
        if (!prr) begin poll++; beat = 0; nb = int'($urandom_range(1, 3)); end
        if (abort) begin
          #1 rst = 1'b1; cmd_ready = 1'b0; rd_valid = 1'b0;
          #1;
          chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
          chk("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
          chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
          chk("rst_fields", {opcode, address, rsp_status}, 64'd0);
          @(negedge clk); rst = 1'b0;
          @(negedge clk);
          chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
          return;
        end
        rd_valid = $urandom_range(0, 3) != 0;
        rd_data = beat == 0 ? {8'($urandom), stat_of(poll)} : 16'($urandom);
        rd_last = beat == nb - 1;
        if (rd_valid) beat++;
      end else begin
        rd_valid = $urandom_range(0, 2) == 0;
        rd_data = {8'($urandom), 8'($urandom) | 8'h41};
        rd_last = 1'($urandom);
      end
      prr = rd_ready;
      if (rsp_valid) begin
        if (!seen) begin seen = 1; rsp_cap = {rsp_status, rsp_fail, rsp_timeout}; hold_left = rsp_hold; end
        else if ({rsp_status, rsp_fail, rsp_timeout} !== rsp_cap) viol++;
        if (req_ready) viol++;
        req_valid = hold_left > 0;
        rsp_ready = hold_left == 0;
        done = hold_left == 0;
        if (hold_left > 0) hold_left--;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    rd_valid = 1'b0;
    chk("done", {63'd0, done}, 64'd1);
    chk("ncmd", 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      m = i >= 3 ? 64'hFFFF_0000_0000_FFFF : '1;
      chk($sformatf("cmd%0d", i), got[i] & m, exp[i] & m);
    end
    chk("status", {56'd0, rsp_cap[9:2]}, {56'd0, st});
    chk("fail", {63'd0, rsp_cap[1]}, {63'd0, st[0]});
    chk("timeout", {63'd0, rsp_cap[0]}, {63'd0, exp_to});
    chk("protocol", 64'(viol), 64'd0);
    chk("rsp_released", {63'd0, rsp_valid}, 64'd0);
    chk("idle", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #2;
    chk("reset_valids", {61'd0, cmd_valid, rsp_valid, rd_ready}, 64'd0);
    chk("reset_fields", {opcode, address, rsp_status, rsp_timeout, rsp_fail}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    stat_seq[0] = 8'h00; stat_seq[1] = 8'h00; stat_seq[2] = 8'h40; stat_n = 3;
    run_op(2'd0, 2'd1, 24'h000003, 16'h0000, 16'd8, 0, 0, 0);
    stat_seq[0] = 8'h00; stat_n = 1;
    run_op(2'd2, 2'd0, 24'h00A5C3, 16'h0000, 16'd0, 0, 0, 0);
    run_op(2'd1, 2'd3, 24'h123456, 16'h0ABC, 16'd2048, 0, 1, 0);
    stat_seq[0] = 8'h40; stat_n = 1;
    run_op(2'd0, 2'd2, 24'hFEDCBA, 16'h1234, 16'd512, 1, 0, 0);
    run_op(2'd0, 2'd1, 24'h000777, 16'h0010, 16'd16, 0, 0, 1);
    run_op(2'd0, 2'd1, 24'h000778, 16'h0020, 16'd32, 0, 0, 0);
    stat_seq[0] = 8'h41; stat_n = 1;
    run_op(2'd2, 2'd0, 24'h0000FF, 16'h0000, 16'd0, 0, 3, 0);
    run_op(2'd3, 2'd2, 24'h00BEEF, 16'h0042, 16'd4, 0, 0, 0);
    for (int k = 0; k < 25; k++) begin
      stat_n = int'($urandom_range(1, 6));
      for (int i = 0; i < 8; i++)
        stat_seq[i] = (8'($urandom) & 8'hBF) | ($urandom_range(0, 2) == 0 ? 8'h40 : 8'h00);
      run_op(2'($urandom_range(0, 3)), 2'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
             1'($urandom), int'($urandom_range(0, 3)), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
